// File: rtl/add16_sequencer.sv
// add16_sequencer: drives a shared 8-bit ripple adder one byte per cycle to
// carry out 8086-style ADD/ADC/SUB/SBB on byte or word operands, and produces
// the result together with the CF/ZF/SF/OF/AF flags.
module add16_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    // request side
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [1:0]  op,
    input  logic        wide,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic        cf_in,
    // shared adder
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_cin,
    input  logic [7:0]  add_sum,
    input  logic        add_cout,
    // result side
    output logic        result_valid,
    input  logic        result_ready,
    output logic [15:0] result,
    output logic        cf,
    output logic        zf,
    output logic        sf,
    output logic        of,
    output logic        af
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t      state_q, state_d;

    // Operands are captured at accept; B is stored already inverted for
    // subtraction so the adder path never has to look at the opcode again.
    logic [15:0] opa_q,    opa_d;
    logic [15:0] beff_q,   beff_d;
    logic        sub_q,    sub_d;
    logic        wide_q,   wide_d;
    logic        cin_lo_q, cin_lo_d;

    // Low-byte results carried into the high-byte cycle.
    logic        carry_q,  carry_d;
    logic [7:0]  sum_lo_q, sum_lo_d;
    logic        af_lo_q,  af_lo_d;

    // Presented result and flags; only written on the final byte so nothing
    // partial ever shows up on the outputs.
    logic [15:0] result_q, result_d;
    logic        cf_q, cf_d;
    logic        zf_q, zf_d;
    logic        sf_q, sf_d;
    logic        of_q, of_d;
    logic        af_q, af_d;

    logic        accept;
    logic        af_now;
    logic        of_now;

    // start_ready is forced low while reset is held so nothing is accepted
    // on the release edge before the design is live.
    assign start_ready  = rst_n && (state_q == S_IDLE);
    assign accept       = start_valid && start_ready;
    assign result_valid = (state_q == S_DONE);

    assign result = result_q;
    assign cf     = cf_q;
    assign zf     = zf_q;
    assign sf     = sf_q;
    assign of     = of_q;
    assign af     = af_q;

    // Adder operand selection: only the two compute states drive the adder.
    always_comb begin
        add_a   = 8'h00;
        add_b   = 8'h00;
        add_cin = 1'b0;
        case (state_q)
            S_LO: begin
                add_a   = opa_q[7:0];
                add_b   = beff_q[7:0];
                add_cin = cin_lo_q;
            end
            S_HI: begin
                add_a   = opa_q[15:8];
                add_b   = beff_q[15:8];
                add_cin = carry_q;
            end
            default: begin
                add_a   = 8'h00;
                add_b   = 8'h00;
                add_cin = 1'b0;
            end
        endcase
    end

    // Per-byte flag terms from whatever byte the adder is working on now.
    // AF is inverted for subtraction so it reports a nibble borrow.
    assign af_now = add_a[4] ^ add_b[4] ^ add_sum[4] ^ sub_q;
    assign of_now = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)       state_d = S_LO;
            S_LO:   state_d = wide_q ? S_HI : S_DONE;
            S_HI:   state_d = S_DONE;
            S_DONE: if (result_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: operand capture, inter-byte carry and final flags.
    always_comb begin
        opa_d    = opa_q;
        beff_d   = beff_q;
        sub_d    = sub_q;
        wide_d   = wide_q;
        cin_lo_d = cin_lo_q;
        carry_d  = carry_q;
        sum_lo_d = sum_lo_q;
        af_lo_d  = af_lo_q;
        result_d = result_q;
        cf_d     = cf_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        of_d     = of_q;
        af_d     = af_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    opa_d  = opa;
                    beff_d = op[1] ? ~opb : opb;
                    sub_d  = op[1];
                    wide_d = wide;
                    case (op)
                        OP_ADD:  cin_lo_d = 1'b0;
                        OP_ADC:  cin_lo_d = cf_in;
                        OP_SUB:  cin_lo_d = 1'b1;
                        OP_SBB:  cin_lo_d = ~cf_in;
                        default: cin_lo_d = 1'b0;
                    endcase
                end
            end
            S_LO: begin
                carry_d  = add_cout;
                sum_lo_d = add_sum;
                af_lo_d  = af_now;
                if (!wide_q) begin
                    result_d = {8'h00, add_sum};
                    cf_d     = add_cout ^ sub_q;
                    zf_d     = (add_sum == 8'h00);
                    sf_d     = add_sum[7];
                    of_d     = of_now;
                    af_d     = af_now;
                end
            end
            S_HI: begin
                result_d = {add_sum, sum_lo_q};
                cf_d     = add_cout ^ sub_q;
                zf_d     = (add_sum == 8'h00) && (sum_lo_q == 8'h00);
                sf_d     = add_sum[7];
                of_d     = of_now;
                af_d     = af_lo_q;
            end
            default: begin
                // DONE holds everything stable under backpressure.
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q    <= 16'h0000;
            beff_q   <= 16'h0000;
            sub_q    <= 1'b0;
            wide_q   <= 1'b0;
            cin_lo_q <= 1'b0;
            carry_q  <= 1'b0;
            sum_lo_q <= 8'h00;
            af_lo_q  <= 1'b0;
            result_q <= 16'h0000;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            of_q     <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            opa_q    <= opa_d;
            beff_q   <= beff_d;
            sub_q    <= sub_d;
            wide_q   <= wide_d;
            cin_lo_q <= cin_lo_d;
            carry_q  <= carry_d;
            sum_lo_q <= sum_lo_d;
            af_lo_q  <= af_lo_d;
            result_q <= result_d;
            cf_q     <= cf_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            of_q     <= of_d;
            af_q     <= af_d;
        end
    end

endmodule

// File: tb/tb_add16_sequencer.sv
// Directed bench for add16_sequencer with a behavioural 8-bit adder attached.
module tb_add16_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid, start_ready;
    logic [1:0]  op;
    logic        wide;
    logic [15:0] opa, opb;
    logic        cf_in;
    logic [7:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        result_valid, result_ready;
    logic [15:0] result;
    logic        cf, zf, sf, of, af;
    logic [4:0]  flags;

    always #5 clk = ~clk;

    // The shared adder the sequencer drives.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
    assign flags = {cf, zf, sf, of, af};

    add16_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .wide(wide), .opa(opa), .opb(opb), .cf_in(cf_in),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result), .cf(cf), .zf(zf), .sf(sf), .of(of), .af(af)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        wide;
        logic [15:0] opa;
        logic [15:0] opb;
        logic        cf_in;
        logic [15:0] res;
        logic [4:0]  flg;     // {cf, zf, sf, of, af}
        int          lat;     // edges from accept edge (inclusive) to valid
        logic [7:0]  lo_a, lo_b;
        logic        lo_cin;
        logic [7:0]  hi_a, hi_b; // second cycle drive (zero when byte op)
        logic        hi_cin;
    } vec_t;

    vec_t vecs[8];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one request, return the observed latency and the adder drive
    // in the first two cycles after accept. result_ready is held low.
    task automatic issue(input vec_t v, output int lat,
                         output logic [7:0] la, output logic [7:0] lb, output logic lc,
                         output logic [7:0] ha, output logic [7:0] hb, output logic hc);
        @(negedge clk);
        result_ready = 1'b0;
        op = v.op; wide = v.wide; opa = v.opa; opb = v.opb; cf_in = v.cf_in;
        start_valid = 1'b1;
        check({v.name, " start_ready"}, {31'd0, start_ready}, 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        opa = 16'hDEAD; opb = 16'hBEEF; op = 2'b00; cf_in = 1'b0;
        lat = 1;
        la = add_a; lb = add_b; lc = add_cin;
        check({v.name, " early_valid"}, {31'd0, result_valid}, 32'd0);
        @(posedge clk); #1;
        lat = 2;
        ha = add_a; hb = add_b; hc = add_cin;
        while (!result_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result(input string name);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk); #1;
        check({name, " valid_cleared"}, {31'd0, result_valid}, 32'd0);
        check({name, " ready_back"}, {31'd0, start_ready}, 32'd1);
        result_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] la, lb, ha, hb;
        logic lc, hc;
        logic [15:0] held_res;
        logic [4:0]  held_flg;

        start_valid = 1'b0; result_ready = 1'b0;
        op = 2'b00; wide = 1'b0; opa = 16'h0; opb = 16'h0; cf_in = 1'b0;

        //          name        op     w   opa       opb       cin  result    cf zf sf of af  lat lo_a   lo_b   lc  hi_a   hi_b   hc
        vecs[0] = '{"add_w",   2'b00, 1, 16'h7FFF, 16'h0001, 0, 16'h8000, 5'b00111, 3, 8'hFF, 8'h01, 0, 8'h7F, 8'h00, 1};
        vecs[1] = '{"sub_w",   2'b10, 1, 16'h0000, 16'h0001, 0, 16'hFFFF, 5'b10101, 3, 8'h00, 8'hFE, 1, 8'h00, 8'hFF, 0};
        vecs[2] = '{"adc_b",   2'b01, 0, 16'h00FF, 16'h0000, 1, 16'h0000, 5'b11001, 2, 8'hFF, 8'h00, 1, 8'h00, 8'h00, 0};
        vecs[3] = '{"sbb_w",   2'b11, 1, 16'h1234, 16'h0234, 1, 16'h0FFF, 5'b00001, 3, 8'h34, 8'hCB, 0, 8'h12, 8'hFD, 0};
        vecs[4] = '{"add_b80", 2'b00, 0, 16'h0080, 16'h0080, 0, 16'h0000, 5'b11010, 2, 8'h80, 8'h80, 0, 8'h00, 8'h00, 0};
        vecs[5] = '{"sub_w8k", 2'b10, 1, 16'h8000, 16'h0001, 0, 16'h7FFF, 5'b00011, 3, 8'h00, 8'hFE, 1, 8'h80, 8'hFF, 0};
        vecs[6] = '{"add_wff", 2'b00, 1, 16'hFFFF, 16'h0001, 1, 16'h0000, 5'b11001, 3, 8'hFF, 8'h01, 0, 8'hFF, 8'h00, 1};
        vecs[7] = '{"sbb_bhi", 2'b11, 0, 16'hAB10, 16'hCD01, 0, 16'h000F, 5'b00001, 2, 8'h10, 8'hFE, 1, 8'h00, 8'h00, 0};

        // Reset state
        #1;
        check("rst start_ready", {31'd0, start_ready}, 32'd0);
        check("rst result_valid", {31'd0, result_valid}, 32'd0);
        check("rst result", {16'd0, result}, 32'd0);
        check("rst flags", {27'd0, flags}, 32'd0);
        check("rst add_bus", {15'd0, add_a, add_b, add_cin}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst start_ready", {31'd0, start_ready}, 32'd1);

        // Table-driven operations
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i], lat, la, lb, lc, ha, hb, hc);
            $display("[TB] %s op=%0d wide=%0d a=%h b=%h cin=%0d -> res=%h flags=%b lat=%0d",
                     vecs[i].name, vecs[i].op, vecs[i].wide, vecs[i].opa, vecs[i].opb,
                     vecs[i].cf_in, result, flags, lat);
            check({vecs[i].name, " latency"}, lat, vecs[i].lat);
            check({vecs[i].name, " result"}, {16'd0, result}, {16'd0, vecs[i].res});
            check({vecs[i].name, " flags"}, {27'd0, flags}, {27'd0, vecs[i].flg});
            check({vecs[i].name, " lo_drive"}, {15'd0, la, lb, lc},
                  {15'd0, vecs[i].lo_a, vecs[i].lo_b, vecs[i].lo_cin});
            check({vecs[i].name, " hi_drive"}, {15'd0, ha, hb, hc},
                  {15'd0, vecs[i].hi_a, vecs[i].hi_b, vecs[i].hi_cin});
            release_result(vecs[i].name);
        end

        // Backpressure: hold the result for 5 cycles while a new request knocks
        issue(vecs[3], lat, la, lb, lc, ha, hb, hc);
        held_res = result;
        held_flg = flags;
        check("bp result", {16'd0, held_res}, 32'h0FFF);
        @(negedge clk);
        start_valid = 1'b1; op = 2'b00; wide = 1'b0; opa = 16'h0001; opb = 16'h0001;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp valid_held", {31'd0, result_valid}, 32'd1);
            check("bp result_stable", {16'd0, result}, {16'd0, held_res});
            check("bp flags_stable", {27'd0, flags}, {27'd0, held_flg});
            check("bp start_ready_low", {31'd0, start_ready}, 32'd0);
        end
        $display("[TB] backpressure held res=%h flags=%b for 5 cycles", result, flags);
        @(negedge clk);
        start_valid = 1'b0;
        release_result("bp");
        @(posedge clk); #1;
        check("bp no_stray_accept", {31'd0, start_ready}, 32'd1);

        // Reset while in HI
        issue(vecs[0], lat, la, lb, lc, ha, hb, hc);
        release_result("pre_rst");
        @(negedge clk);
        op = 2'b00; wide = 1'b1; opa = 16'h7FFF; opb = 16'h0001; cf_in = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;            // accept -> LO
        start_valid = 1'b0;
        @(posedge clk); #1;            // LO -> HI
        check("midrst in_hi", {15'd0, add_a, add_b, add_cin}, {15'd0, 8'h7F, 8'h00, 1'b1});
        #1 rst_n = 1'b0;
        #1;
        check("midrst result", {16'd0, result}, 32'd0);
        check("midrst flags", {27'd0, flags}, 32'd0);
        check("midrst valid", {31'd0, result_valid}, 32'd0);
        check("midrst start_ready", {31'd0, start_ready}, 32'd0);
        check("midrst add_bus", {15'd0, add_a, add_b, add_cin}, 32'd0);
        $display("[TB] reset in HI: res=%h flags=%b valid=%0d", result, flags, result_valid);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            vec_t v;
            v = '{"fresh_add", 2'b00, 1, 16'h0001, 16'h0001, 0, 16'h0002, 5'b00000, 3,
                  8'h01, 8'h01, 0, 8'h00, 8'h00, 0};
            issue(v, lat, la, lb, lc, ha, hb, hc);
            $display("[TB] fresh_add after reset -> res=%h flags=%b lat=%0d", result, flags, lat);
            check("fresh latency", lat, 3);
            check("fresh result", {16'd0, result}, 32'h0002);
            check("fresh flags", {27'd0, flags}, 32'd0);
            release_result("fresh");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
